// File: rtl/bcd_result_encoder_if.sv
// Handshake and result bundle between the ALU-side requester and the BCD encoder.
// The master drives the request; the slave (encoder) returns status and digits.
interface bcd_result_encoder_if;
  logic       start;
  logic [8:0] value;
  logic       ovf_in;
  logic       busy;
  logic       done;
  logic [3:0] units;
  logic [3:0] tens;
  logic [1:0] hundreds;
  logic       zero;
  logic       overflow;

  modport master (
    output start, value, ovf_in,
    input  busy, done, units, tens, hundreds, zero, overflow
  );

  modport slave (
    input  start, value, ovf_in,
    output busy, done, units, tens, hundreds, zero, overflow
  );
endinterface

// File: rtl/bcd_result_encoder.sv
// Sequential double-dabble converter: 9-bit ALU result to registered BCD digits
// with Zero/Overflow flags for the seven-segment decoder.
module bcd_result_encoder #(
  parameter int unsigned LIMIT = 299
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_result_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } state_t;

  localparam logic [9:0] LIMIT_W = 10'(LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] scratch_q, scratch_d;
  logic [11:0] scratch_adj;
  logic [8:0]  shift_q, shift_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [3:0]  units_q, units_d;
  logic [3:0]  tens_q, tens_d;
  logic [1:0]  hund_q, hund_d;
  logic        zero_q, zero_d;
  logic        overflow_q, overflow_d;

  // Nibble correction stays inside 4 bits; a digit never exceeds 9 so no carry is lost.
  function automatic logic [3:0] dabble(input logic [3:0] nib);
    return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
  endfunction

  assign scratch_adj = {dabble(scratch_q[11:8]), dabble(scratch_q[7:4]), dabble(scratch_q[3:0])};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scratch_d  = scratch_q;
    shift_d    = shift_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    units_d    = units_q;
    tens_d     = tens_q;
    hund_d     = hund_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = bus.value;
          scratch_d = '0;
          cnt_d     = 4'd9;
          ovf_d     = bus.ovf_in | ({1'b0, bus.value} > LIMIT_W);
          state_d   = CONV;
        end
      end
      CONV: begin
        {scratch_d, shift_d} = {scratch_adj[10:0], shift_q, 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (ovf_q) begin
          units_d    = 4'd0;
          tens_d     = 4'd0;
          hund_d     = 2'd0;
          zero_d     = 1'b0;
          overflow_d = 1'b1;
        end else begin
          units_d    = scratch_q[3:0];
          tens_d     = scratch_q[7:4];
          hund_d     = scratch_q[9:8];
          zero_d     = (scratch_q == 12'd0);
          overflow_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      scratch_q  <= 12'd0;
      shift_q    <= 9'd0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      units_q    <= 4'd0;
      tens_q     <= 4'd0;
      hund_q     <= 2'd0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scratch_q  <= scratch_d;
      shift_q    <= shift_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      units_q    <= units_d;
      tens_q     <= tens_d;
      hund_q     <= hund_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.units    = units_q;
  assign bus.tens     = tens_q;
  assign bus.hundreds = hund_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bcd_result_encoder.sv
// Scoreboard bench for bcd_result_encoder: default LIMIT instance plus a LIMIT=99 instance.
module tb_bcd_result_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_result_encoder_if bus();
  bcd_result_encoder_if bus99();

  bcd_result_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  bcd_result_encoder #(.LIMIT(99)) dut99 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus99.slave)
  );

  localparam logic [11:0] RESET_OUT = {4'd0, 4'd0, 2'd0, 1'b1, 1'b0};

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  // Expected {units, tens, hundreds, zero, overflow} from plain arithmetic.
  function automatic logic [11:0] exp_of(input int v, input bit o, input int lim);
    logic [3:0] u, t;
    logic [1:0] h;
    if (o || v > lim) return {4'd0, 4'd0, 2'd0, 1'b0, 1'b1};
    u = 4'(v % 10);
    t = 4'((v / 10) % 10);
    h = 2'(v / 100);
    return {u, t, h, (v == 0), 1'b0};
  endfunction

  // Cycle model of the default instance: acceptance, busy window, done pulse.
  int          m_cnt;
  bit          m_done;
  logic [11:0] sbq[$];
  logic [11:0] sbq99[$];
  logic [11:0] held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_done = 0;
      sbq.delete();
    end else begin
      m_done = (m_cnt == 1);
      if (m_cnt == 0 && bus.start) begin
        sbq.push_back(exp_of(int'(bus.value), bus.ovf_in, 299));
        m_cnt = 10;
      end else if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
      end
    end
  end

  function automatic logic [11:0] outs();
    return {bus.units, bus.tens, bus.hundreds, bus.zero, bus.overflow};
  endfunction

  function automatic logic [11:0] outs99();
    return {bus99.units, bus99.tens, bus99.hundreds, bus99.zero, bus99.overflow};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.value = '0; bus.ovf_in = 1'b0;
    bus99.start = 1'b0; bus99.value = '0; bus99.ovf_in = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      nerr++; $display("FAIL reset_status: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    nvec++;
    if (outs() !== RESET_OUT) begin
      nerr++; $display("FAIL reset_outputs: got %h expected %h", outs(), RESET_OUT);
    end
    nvec++;
    if (outs99() !== RESET_OUT || bus99.busy !== 1'b0) begin
      nerr++; $display("FAIL reset_outputs99: got %h busy=%b expected %h busy=0", outs99(), bus99.busy, RESET_OUT);
    end
    held = RESET_OUT;
    rst_n = 1'b1;
  endtask

  task automatic test_singles();
    int  vals[7] = '{0, 137, 299, 300, 511, 5, 0};
    bit  ovfs[7] = '{0, 0, 0, 0, 0, 1, 0};
    logic [11:0] e;
    bit got;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.value = 9'(vals[k]); bus.ovf_in = ovfs[k];
      @(negedge clk);
      bus.start = 1'b0; bus.value = 9'($urandom); bus.ovf_in = 1'($urandom);
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        nvec++;
        if (bus.busy !== (m_cnt != 0)) begin
          nerr++; $display("FAIL single_busy v=%0d c=%0d: got %b expected %b", vals[k], c, bus.busy, (m_cnt != 0));
        end
        nvec++;
        if (bus.done !== m_done) begin
          nerr++; $display("FAIL single_done v=%0d c=%0d: got %b expected %b", vals[k], c, bus.done, m_done);
        end
        if (bus.done === 1'b1) begin
          got = 1;
          nvec++;
          if (sbq.size() == 0) begin
            nerr++; $display("FAIL single_result v=%0d: got done with %h expected no output", vals[k], outs());
          end else begin
            e = sbq.pop_front();
            if (outs() !== e) begin
              nerr++; $display("FAIL single_result v=%0d: got %h expected %h", vals[k], outs(), e);
            end
            held = e;
          end
        end else begin
          nvec++;
          if (outs() !== held) begin
            nerr++; $display("FAIL single_hold v=%0d c=%0d: got %h expected %h", vals[k], c, outs(), held);
          end
          @(negedge clk);
        end
      end
      if (!got) begin
        nvec++; nerr++; $display("FAIL single_timeout v=%0d: got no done expected done", vals[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int results = 0;
    logic [11:0] e;
    @(negedge clk);
    bus.ovf_in = 1'b0;
    bus.start = 1'b1;
    for (int c = 0; c < 300 * 11 + 60 && results < 300; c++) begin
      if (m_cnt == 10) idx++;
      nvec++;
      if (bus.busy !== (m_cnt != 0)) begin
        nerr++; $display("FAIL b2b_busy c=%0d: got %b expected %b", c, bus.busy, (m_cnt != 0));
      end
      nvec++;
      if (bus.done !== m_done) begin
        nerr++; $display("FAIL b2b_done c=%0d: got %b expected %b", c, bus.done, m_done);
      end
      if (bus.done === 1'b1) begin
        results++;
        nvec++;
        if (sbq.size() == 0) begin
          nerr++; $display("FAIL b2b_result c=%0d: got done with %h expected no output", c, outs());
        end else begin
          e = sbq.pop_front();
          if (outs() !== e) begin
            nerr++; $display("FAIL b2b_result c=%0d: got %h expected %h", c, outs(), e);
          end
          held = e;
        end
      end else if (outs() !== held) begin
        nvec++; nerr++;
        $display("FAIL b2b_hold c=%0d: got %h expected %h", c, outs(), held);
      end
      if (m_cnt == 0) begin
        if (idx >= 300) bus.start = 1'b0;
        else bus.value = 9'(idx);
      end else begin
        bus.value = 9'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    nvec++;
    if (results != 300) begin
      nerr++; $display("FAIL b2b_count: got %0d results expected 300", results);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    bit got = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.value = 9'd250; bus.ovf_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    nvec++;
    if (bus.busy !== 1'b1 || outs() !== held) begin
      nerr++; $display("FAIL midreset_pre: got busy=%b out=%h expected busy=1 out=%h", bus.busy, outs(), held);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if (outs() !== RESET_OUT || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      nerr++; $display("FAIL midreset_now: got out=%h busy=%b done=%b expected %h 0 0", outs(), bus.busy, bus.done, RESET_OUT);
    end
    held = RESET_OUT;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) begin
        rst_n = 1'b1;
        bus.start = 1'b1; bus.value = 9'd42;
      end else if (c == 4) begin
        bus.start = 1'b0; bus.value = 9'($urandom);
      end
      nvec++;
      if (bus.done !== 1'b0) begin
        nerr++; $display("FAIL midreset_nodone c=%0d: got done=%b expected 0", c, bus.done);
      end
    end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1;
        nvec++;
        if (sbq.size() != 1) begin
          nerr++; $display("FAIL midreset_queue: got %0d pending expected 1", sbq.size());
        end else begin
          e = sbq.pop_front();
          if (outs() !== e || e !== exp_of(42, 0, 299)) begin
            nerr++; $display("FAIL midreset_result: got %h expected %h", outs(), exp_of(42, 0, 299));
          end
          held = e;
        end
      end
    end
    if (!got) begin
      nvec++; nerr++; $display("FAIL midreset_timeout: got no done expected done");
    end
  endtask

  task automatic test_limit99();
    int  vals[5] = '{99, 100, 0, 55, 7};
    bit  ovfs[5] = '{0, 0, 0, 0, 1};
    logic [11:0] e;
    bit got;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus99.start = 1'b1; bus99.value = 9'(vals[k]); bus99.ovf_in = ovfs[k];
      sbq99.push_back(exp_of(vals[k], ovfs[k], 99));
      @(negedge clk);
      bus99.start = 1'b0; bus99.value = 9'($urandom); bus99.ovf_in = 1'($urandom);
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        if (bus99.done === 1'b1) begin
          got = 1;
          e = sbq99.pop_front();
          nvec++;
          if (outs99() !== e) begin
            nerr++; $display("FAIL limit99 v=%0d: got %h expected %h", vals[k], outs99(), e);
          end
        end else begin
          @(negedge clk);
        end
      end
      if (!got) begin
        nvec++; nerr++; $display("FAIL limit99_timeout v=%0d: got no done expected done", vals[k]);
        sbq99.delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_singles();
    test_back_to_back();
    test_reset_mid();
    test_limit99();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
